// File: rtl/multicycle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_pkg
//  Description : Shared sequencer types: state encoding, opcode class
//                constants and the class-to-step-count function.
//  Revision    : 1.0 - initial release
// ============================================================================
package multicycle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [3:0] c_CLASS_NOP  = 4'h0;
    localparam logic [3:0] c_CLASS_HALT = 4'hF;

    // Number of micro-steps for an opcode class; HALT reports 1 but never executes.
    function automatic logic [3:0] class_steps(input logic [3:0] op_class);
        logic [3:0] v_count;
        v_count = 4'd1;
        if (op_class == c_CLASS_NOP) begin
            v_count = 4'd1;
        end else if (op_class <= 4'h7) begin
            v_count = 4'd2;
        end else if (op_class <= 4'hB) begin
            v_count = 4'd3;
        end else if (op_class <= 4'hE) begin
            v_count = 4'd2;
        end else begin
            v_count = 4'd1;
        end
        return v_count;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_sequencer_opclass_steps.sv
`default_nettype none
// ============================================================================
//  Module      : opclass_steps
//  Description : Combinational lookup from opcode class to micro-step count.
//  Revision    : 1.0 - initial release
// ============================================================================
module opclass_steps
    import multicycle_pkg::*;
#(
    parameter int STEP_W = 3
) (
    input  logic [3:0]      op_class,
    output logic [STEP_W:0] count
);

    logic [3:0] w_count4;

    // Table lookup resized to the step-count width.
    always_comb begin
        w_count4 = class_steps(op_class);
        count    = (STEP_W + 1)'(w_count4);
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_sequencer
//  Description : Walks each accepted opcode through its micro-steps, supports
//                back-to-back issue, a run enable and a HALT/resume state.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer
    import multicycle_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int STEP_W   = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] instr_in,
    input  logic                resume,
    output logic                instr_ready,
    output logic [OPCODE_W-1:0] opcode_out,
    output logic [STEP_W-1:0]   step,
    output logic                last_step,
    output logic                instr_done,
    output logic                halted
);

    localparam logic [STEP_W-1:0] c_STEP_ONE = 1;
    localparam logic [STEP_W:0]   c_CNT_ONE  = 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [OPCODE_W-1:0] r_opcode;
    logic [OPCODE_W-1:0] w_opcode_nxt;
    logic [STEP_W-1:0]   r_step;
    logic [STEP_W-1:0]   w_step_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic [STEP_W:0]     w_count;
    logic                w_last;
    logic                w_ready;
    logic                w_accept;
    logic [3:0]          w_in_class;

    assign w_in_class = instr_in[OPCODE_W-1 -: 4];

    // Step count of the instruction currently being executed.
    opclass_steps #(
        .STEP_W   (STEP_W)
    ) u_opclass_steps (
        .op_class (r_opcode[OPCODE_W-1 -: 4]),
        .count    (w_count)
    );

    // Handshake and step-status decode from the current state.
    always_comb begin
        w_last   = (r_state == ST_EXEC) && ({1'b0, r_step} == (w_count - c_CNT_ONE));
        w_ready  = run && ((r_state == ST_IDLE) || w_last);
        w_accept = w_ready && instr_valid;
    end

    // Next-state logic; everything holds while run is low.
    always_comb begin
        w_state_nxt  = r_state;
        w_opcode_nxt = r_opcode;
        w_step_nxt   = r_step;
        w_done_nxt   = 1'b0;
        if (run) begin
            w_done_nxt = w_last;
            if (w_accept) begin
                w_opcode_nxt = instr_in;
                w_step_nxt   = '0;
                w_state_nxt  = (w_in_class == c_CLASS_HALT) ? ST_HALTED : ST_EXEC;
            end else begin
                case (r_state)
                    ST_EXEC: begin
                        if (w_last) begin
                            w_state_nxt = ST_IDLE;
                            w_step_nxt  = '0;
                        end else begin
                            w_step_nxt  = r_step + c_STEP_ONE;
                        end
                    end
                    ST_HALTED: begin
                        if (resume) begin
                            w_state_nxt = ST_IDLE;
                            w_step_nxt  = '0;
                        end
                    end
                    default: begin
                        w_state_nxt = r_state;
                    end
                endcase
            end
        end
    end

    // Single state register; reset abandons any instruction silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_opcode <= '0;
            r_step   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_opcode <= w_opcode_nxt;
            r_step   <= w_step_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign instr_ready = w_ready;
    assign opcode_out  = r_opcode;
    assign step        = r_step;
    assign last_step   = w_last;
    assign instr_done  = r_done;
    assign halted      = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_sequencer
//  Description : Directed vector bench for multicycle_sequencer. Each vector
//                drives one cycle of inputs and lists the outputs expected in
//                that same cycle (state from the previous edge).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

    typedef struct {
        logic       rst;
        logic       run;
        logic       vld;
        logic [7:0] instr;
        logic       res;
        logic       rdy;
        logic [7:0] op;
        logic [2:0] stp;
        logic       last;
        logic       done;
        logic       halt;
    } vec_t;

    logic       clock;
    logic       reset;
    logic       run;
    logic       instr_valid;
    logic [7:0] instr_in;
    logic       resume;
    logic       instr_ready;
    logic [7:0] opcode_out;
    logic [2:0] step;
    logic       last_step;
    logic       instr_done;
    logic       halted;

    int   n_checks;
    int   n_errors;
    int   n_vec;
    vec_t tbl [64];

    multicycle_sequencer #(
        .OPCODE_W    (8),
        .STEP_W      (3)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .instr_valid (instr_valid),
        .instr_in    (instr_in),
        .resume      (resume),
        .instr_ready (instr_ready),
        .opcode_out  (opcode_out),
        .step        (step),
        .last_step   (last_step),
        .instr_done  (instr_done),
        .halted      (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Append a vector: inputs rst run vld instr res, then expected outputs.
    task automatic add(input logic rst, input logic rn, input logic vl, input logic [7:0] ins,
                       input logic rs, input logic rdy, input logic [7:0] op,
                       input logic [2:0] st, input logic ls, input logic dn, input logic hl);
        tbl[n_vec] = '{rst, rn, vl, ins, rs, rdy, op, st, ls, dn, hl};
        n_vec++;
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL vec%0d %s: got %h expected %h", idx, name, got, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clock);
        reset       = v.rst;
        run         = v.run;
        instr_valid = v.vld;
        instr_in    = v.instr;
        resume      = v.res;
        #1;
        check("instr_ready", idx, {7'd0, instr_ready}, {7'd0, v.rdy});
        check("opcode_out",  idx, opcode_out,          v.op);
        check("step",        idx, {5'd0, step},        {5'd0, v.stp});
        check("last_step",   idx, {7'd0, last_step},   {7'd0, v.last});
        check("instr_done",  idx, {7'd0, instr_done},  {7'd0, v.done});
        check("halted",      idx, {7'd0, halted},      {7'd0, v.halt});
    endtask

    initial begin
        vec_t hv;
        n_checks    = 0;
        n_errors    = 0;
        n_vec       = 0;
        reset       = 1'b1;
        run         = 1'b1;
        instr_valid = 1'b0;
        instr_in    = 8'h00;
        resume      = 1'b0;

        //  rst run vld instr res | rdy  op    st   last done halt
        // 0x25: two steps, done, back to IDLE (first vector = reset state)
        add(0, 1, 1, 8'h25, 0,   1, 8'h00, 3'd0, 0, 0, 0);
        add(0, 1, 0, 8'h00, 0,   0, 8'h25, 3'd0, 0, 0, 0);
        add(0, 1, 0, 8'h00, 0,   1, 8'h25, 3'd1, 1, 0, 0);
        add(0, 1, 0, 8'h00, 0,   1, 8'h25, 3'd0, 0, 1, 0);
        // 0x81 three steps, 0x03 issued back-to-back on the last step
        add(0, 1, 1, 8'h81, 0,   1, 8'h25, 3'd0, 0, 0, 0);
        add(0, 1, 1, 8'h03, 0,   0, 8'h81, 3'd0, 0, 0, 0);
        add(0, 1, 1, 8'h03, 0,   0, 8'h81, 3'd1, 0, 0, 0);
        add(0, 1, 1, 8'h03, 0,   1, 8'h81, 3'd2, 1, 0, 0);
        add(0, 1, 0, 8'h00, 0,   1, 8'h03, 3'd0, 1, 1, 0);
        add(0, 1, 0, 8'h00, 0,   1, 8'h03, 3'd0, 0, 1, 0);
        // 0x00 single step
        add(0, 1, 1, 8'h00, 0,   1, 8'h03, 3'd0, 0, 0, 0);
        add(0, 1, 0, 8'h00, 0,   1, 8'h00, 3'd0, 1, 0, 0);
        add(0, 1, 0, 8'h00, 0,   1, 8'h00, 3'd0, 0, 1, 0);
        // 0xA0 with run dropped for three cycles at step 1
        add(0, 1, 1, 8'hA0, 0,   1, 8'h00, 3'd0, 0, 0, 0);
        add(0, 1, 0, 8'h00, 0,   0, 8'hA0, 3'd0, 0, 0, 0);
        add(0, 0, 0, 8'h00, 0,   0, 8'hA0, 3'd1, 0, 0, 0);
        add(0, 0, 1, 8'hF0, 1,   0, 8'hA0, 3'd1, 0, 0, 0);
        add(0, 0, 0, 8'h00, 0,   0, 8'hA0, 3'd1, 0, 0, 0);
        add(0, 1, 0, 8'h00, 0,   0, 8'hA0, 3'd1, 0, 0, 0);
        add(0, 1, 0, 8'h00, 0,   1, 8'hA0, 3'd2, 1, 0, 0);
        add(0, 1, 0, 8'h00, 0,   1, 8'hA0, 3'd0, 0, 1, 0);
        // 0xF0 halt, instr_valid ignored, resume to IDLE, resume ignored in IDLE
        add(0, 1, 1, 8'hF0, 0,   1, 8'hA0, 3'd0, 0, 0, 0);
        add(0, 1, 1, 8'h25, 0,   0, 8'hF0, 3'd0, 0, 0, 1);
        add(0, 1, 1, 8'h25, 0,   0, 8'hF0, 3'd0, 0, 0, 1);
        add(0, 1, 0, 8'h00, 1,   0, 8'hF0, 3'd0, 0, 0, 1);
        add(0, 1, 0, 8'h00, 1,   1, 8'hF0, 3'd0, 0, 0, 0);
        // reset at step 1 of 0x90
        add(0, 1, 1, 8'h90, 0,   1, 8'hF0, 3'd0, 0, 0, 0);
        add(0, 1, 0, 8'h00, 0,   0, 8'h90, 3'd0, 0, 0, 0);
        add(1, 1, 0, 8'h00, 0,   0, 8'h90, 3'd1, 0, 0, 0);
        add(0, 0, 0, 8'h00, 0,   0, 8'h00, 3'd0, 0, 0, 0);
        add(0, 1, 0, 8'h00, 0,   1, 8'h00, 3'd0, 0, 0, 0);
        // reset while halted
        add(0, 1, 1, 8'hF0, 0,   1, 8'h00, 3'd0, 0, 0, 0);
        add(1, 1, 0, 8'h00, 0,   0, 8'hF0, 3'd0, 0, 0, 1);
        add(0, 1, 0, 8'h00, 0,   1, 8'h00, 3'd0, 0, 0, 0);

        repeat (2) @(posedge clock);
        for (int i = 0; i < n_vec; i++) begin
            apply(i, tbl[i]);
        end

        // Hand sequence: resume must be ignored while run is low in HALTED.
        hv = '{0, 1, 1, 8'hF5, 0, 1, 8'h00, 3'd0, 0, 0, 0}; apply(100, hv);
        hv = '{0, 0, 0, 8'h00, 1, 0, 8'hF5, 3'd0, 0, 0, 1}; apply(101, hv);
        hv = '{0, 0, 0, 8'h00, 1, 0, 8'hF5, 3'd0, 0, 0, 1}; apply(102, hv);
        hv = '{0, 1, 0, 8'h00, 1, 0, 8'hF5, 3'd0, 0, 0, 1}; apply(103, hv);
        hv = '{0, 1, 0, 8'h00, 0, 1, 8'hF5, 3'd0, 0, 0, 0}; apply(104, hv);
        // Hand sequence: 0xC4 (two steps) ends with no accept, single done pulse.
        hv = '{0, 1, 1, 8'hC4, 0, 1, 8'hF5, 3'd0, 0, 0, 0}; apply(105, hv);
        hv = '{0, 1, 0, 8'h00, 0, 0, 8'hC4, 3'd0, 0, 0, 0}; apply(106, hv);
        hv = '{0, 1, 0, 8'h00, 0, 1, 8'hC4, 3'd1, 1, 0, 0}; apply(107, hv);
        hv = '{0, 1, 0, 8'h00, 0, 1, 8'hC4, 3'd0, 0, 1, 0}; apply(108, hv);
        hv = '{0, 1, 0, 8'h00, 0, 1, 8'hC4, 3'd0, 0, 0, 0}; apply(109, hv);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 The block SHALL have parameter OPCODE_W, default 8, giving the instruction opcode width; legal values are 4 or more.
REQ-002 The block SHALL have parameter STEP_W, default 3, giving the micro-step counter width; every table count SHALL be at most 2**STEP_W.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port run, input, 1 bit: global enable; when low, all state holds.
REQ-006 The block SHALL have port instr_valid, input, 1 bit: instr_in carries a new opcode.
REQ-007 The block SHALL have port instr_in, input, OPCODE_W bits: opcode from the multicycle decoder.
REQ-008 The block SHALL have port resume, input, 1 bit: leave HALTED.
REQ-009 The block SHALL have port instr_ready, output, 1 bit: the block accepts instr_in this cycle.
REQ-010 The block SHALL have port opcode_out, output, OPCODE_W bits: opcode held for the whole instruction.
REQ-011 The block SHALL have port step, output, STEP_W bits: current micro-step, 0-based.
REQ-012 The block SHALL have port last_step, output, 1 bit: the current step is the final step of the instruction.
REQ-013 The block SHALL have port instr_done, output, 1 bit: one-cycle pulse after an instruction's final step.
REQ-014 The block SHALL have port halted, output, 1 bit: the block is in HALTED.

Function
REQ-015 The opcode class SHALL be instr_in[OPCODE_W-1:OPCODE_W-4].
REQ-016 The step count for each class SHALL be:
- 0x0 gives 1 step.
- 0x1 to 0x7 give 2 steps.
- 0x8 to 0xB give 3 steps.
- 0xC to 0xE give 2 steps.
- 0xF is HALT.
REQ-017 The state machine SHALL have three states: IDLE, EXEC and HALTED.
REQ-018 instr_ready SHALL be run and (IDLE, or EXEC with last_step); it is never high in HALTED.
REQ-019 An accept SHALL be instr_valid and instr_ready at a clock edge.
REQ-020 On accept, opcode_out SHALL load instr_in and step SHALL become 0.
REQ-021 On accept, the next state SHALL be EXEC, or HALTED if the class is 0xF.
REQ-022 Latency: an opcode accepted at edge N SHALL be visible on opcode_out and step=0 from edge N onward.
REQ-023 In EXEC with run high and not last_step, step SHALL increment by 1 per cycle.
REQ-024 last_step SHALL be high exactly when the state is EXEC and step equals count-1.
REQ-025 In EXEC with last_step and run high and no accept, the state SHALL return to IDLE.
REQ-026 In EXEC with last_step and an accept, the next instruction SHALL load without a bubble (back-to-back).
REQ-027 instr_done SHALL be a register set for one cycle after any edge where last_step and run were high, including the back-to-back case.
REQ-028 instr_done SHALL be 0 in all other cycles.
REQ-029 A 1-step class SHALL assert last_step in its only step, at step 0.
REQ-030 While run is low:
- state, step and opcode_out SHALL hold.
- instr_ready SHALL be 0.
- instr_done SHALL be 0.
- instr_valid and resume SHALL be ignored.
REQ-031 In HALTED, halted SHALL be 1 and opcode_out SHALL hold the HALT opcode.
REQ-032 In HALTED, resume with run SHALL move the state to IDLE with step=0; resume SHALL be ignored in other states.
REQ-033 step SHALL never wrap: the maximum step value is count-1.

Reset
REQ-034 reset SHALL be sampled on the rising clock edge and SHALL take priority over run and all other inputs.
REQ-035 Reset SHALL force state IDLE, opcode_out 0, step 0, instr_done 0, last_step 0 and halted 0.
REQ-036 instr_ready SHALL follow run in the first cycle after reset.
REQ-037 Reset asserted mid-EXEC or in HALTED SHALL abandon the instruction without an instr_done pulse.

Structure
REQ-038 The state enum, class constants and step-count function SHALL live in a shared package, multicycle_pkg, so the control unit can reuse them.
REQ-039 The step-count lookup SHALL be a sub-module, opclass_steps: combinational, class in, count out.
REQ-040 All other logic SHALL be in one sequential process plus combinational outputs.

Verification
REQ-041 Reset then run=1; accept 0x25 -> step 0,1; last_step at step 1; instr_done the next cycle; then IDLE.
REQ-042 Accept 0x81 with instr_valid held and next opcode 0x03 presented -> steps 0,1,2, then 0x03 loads at step 0 with no idle cycle, and instr_done pulses once.
REQ-043 Accept 0x00 -> one cycle with last_step=1 at step 0, then instr_done.
REQ-044 Drop run for 3 cycles mid-0xA0 at step 1 -> step, opcode_out and state hold and instr_done stays 0; on resume, steps 2 and then done.
REQ-045 Accept 0xF0 -> halted=1 and instr_ready=0; instr_valid is ignored; resume=1 -> IDLE, halted=0.
REQ-046 Assert reset at step 1 of 0x90 -> next cycle IDLE, opcode_out=0, step=0, and no instr_done.
